// File: rtl/pcu_pkg.sv
// pcu_pkg: opcode/funct/ALUop/branch encodings, control word and FSM state for pipe_control_unit
package pcu_pkg;
  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_IMM  = 7'h13;
  localparam logic [6:0] OP_ANDI = 7'h1B;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_LUI  = 7'h38;
  localparam logic [6:0] OP_ST   = 7'h23;
  localparam logic [6:0] OP_HALT = 7'h00;
  localparam logic [2:0] F3_ORI = 3'd7;
  localparam logic [2:0] F3_BNE = 3'd1;
  localparam logic [2:0] F3_LH  = 3'd2;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ADD  = 7'h20;
  localparam logic [6:0] F7_SUB  = 7'h22;
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;
  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_JUMP = 2'd3;
  localparam logic [1:0] SRC_RS2 = 2'd0;
  localparam logic [1:0] SRC_IMM = 2'd1;
  localparam logic [1:0] SRC_PC  = 2'd2;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       memto_reg;
    logic       mem_write;
    logic       sb;
    logic       lh;
    logic       ld;
    logic [1:0] branch;
    logic [1:0] alu_src;
    logic [3:0] alu_op;
  } ctrl_t;
  localparam ctrl_t BUBBLE = '0;
  // {hit, aluop}; a miss marks the R-type as illegal
  function automatic logic [4:0] r_lookup(input logic [2:0] f3, input logic [6:0] f7);
    case ({f3, f7})
      {3'd0, F7_BASE}: return {1'b1, ALU_AND};
      {3'd1, F7_ADD}:  return {1'b1, ALU_ADD};
      {3'd1, F7_SUB}:  return {1'b1, ALU_SUB};
      {3'd2, F7_BASE}: return {1'b1, ALU_OR};
      {3'd3, F7_BASE}: return {1'b1, ALU_XOR};
      {3'd4, F7_BASE}: return {1'b1, ALU_SLL};
      {3'd5, F7_BASE}: return {1'b1, ALU_SRL};
      default:         return 5'd0;
    endcase
  endfunction
  function automatic ctrl_t alu_wb(input logic [1:0] src, input logic [3:0] op);
    ctrl_t c;
    c = BUBBLE;
    c.valid = 1'b1;
    c.reg_write = 1'b1;
    c.memto_reg = 1'b1;
    c.alu_src = src;
    c.alu_op = op;
    return c;
  endfunction
endpackage

// File: rtl/pcu_decode.sv
// pcu_decode: combinational instruction decode; halt and illegal instructions yield a bubble
module pcu_decode
  import pcu_pkg::*;
(
  input  logic [6:0] opCode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       is_halt
);
  logic [4:0] rl;
  always_comb begin
    ctrl = BUBBLE;
    rl = r_lookup(funct3, funct7);
    is_halt = opCode == OP_HALT;
    case (opCode)
      OP_R:    ctrl = rl[4] ? alu_wb(SRC_RS2, rl[3:0]) : BUBBLE;
      OP_IMM:  ctrl = alu_wb(SRC_IMM, funct3 == F3_ORI ? ALU_OR : ALU_ADD);
      OP_ANDI: ctrl = alu_wb(SRC_IMM, ALU_AND);
      OP_LUI:  ctrl = alu_wb(SRC_IMM, ALU_LUI);
      OP_JALR: begin
        ctrl = alu_wb(SRC_IMM, ALU_ADD);
        ctrl.branch = BR_JUMP;
      end
      OP_JAL: begin
        ctrl = alu_wb(SRC_PC, ALU_ADD);
        ctrl.branch = BR_JUMP;
      end
      OP_LOAD: begin
        ctrl = alu_wb(SRC_IMM, ALU_ADD);
        ctrl.memto_reg = 1'b0;
        ctrl.ld = 1'b1;
        ctrl.lh = funct3 == F3_LH;
      end
      OP_BR: begin
        ctrl.valid = 1'b1;
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = funct3 == F3_BNE ? BR_BNE : BR_BEQ;
      end
      OP_ST: begin
        ctrl.valid = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.sb = funct3 == F3_SB;
        ctrl.alu_src = SRC_IMM;
        ctrl.alu_op = ALU_ADD;
      end
      default: ctrl = BUBBLE;
    endcase
  end
endmodule

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: ID/EX control register, RUN/DRAIN/HALTED FSM and decode counter.
// Define PCU_ILLEGAL_TRAP_EN to make an accepted illegal instruction set illegal and drain like halt.
module pipe_control_unit
  import pcu_pkg::*;
#(
  parameter int ALUOP_W      = 4,
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opCode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               inValid,
  input  logic               stall,
  input  logic               flush,
  output logic               exValid,
  output logic               regWrite,
  output logic               memtoReg,
  output logic               memWrite,
  output logic               sb,
  output logic               lh,
  output logic               ld,
  output logic [1:0]         branch,
  output logic [1:0]         ALUsrc,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               halt,
  output logic               illegal,
  output logic [CNT_W-1:0]   decCount
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DLOAD = DW'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);
  state_t state, state_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  ctrl_t d, q;
  logic is_halt, acc, trap;
  pcu_decode u_dec (.opCode(opCode), .funct3(funct3), .funct7(funct7), .ctrl(d), .is_halt(is_halt));
  assign acc = state == RUN && inValid && !stall && !flush;
`ifdef PCU_ILLEGAL_TRAP_EN
  logic ill_q;
  assign trap = acc && !d.valid;
  assign illegal = ill_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ill_q <= 1'b0;
    else if (acc && !d.valid && !is_halt) ill_q <= 1'b1;
`else
  assign trap = acc && is_halt;
  assign illegal = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    dcnt_nx = dcnt;
    if (trap) begin
      state_nx = DRAIN_CYCLES == 0 ? HALTED : DRAIN;
      dcnt_nx = DLOAD;
    end else if (state == DRAIN) begin
      state_nx = dcnt == '0 ? HALTED : DRAIN;
      dcnt_nx = dcnt == '0 ? dcnt : dcnt - DW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      dcnt <= '0;
      q <= BUBBLE;
      decCount <= '0;
    end else begin
      state <= state_nx;
      dcnt <= dcnt_nx;
      if (flush) q <= BUBBLE;
      else if (!stall) q <= state == RUN && inValid ? d : BUBBLE;
      if (acc && d.valid && !(&decCount)) decCount <= decCount + CNT_W'(1);
    end
  assign exValid = q.valid;
  assign regWrite = q.reg_write;
  assign memtoReg = q.memto_reg;
  assign memWrite = q.mem_write;
  assign sb = q.sb;
  assign lh = q.lh;
  assign ld = q.ld;
  assign branch = q.branch;
  assign ALUsrc = q.alu_src;
  assign ALUop = ALUOP_W'(q.alu_op);
  assign halt = state == HALTED;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed + randomized checks of two pipe_control_unit instances against a behavioural model
module tb_pipe_control_unit;
`ifdef PCU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opCode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic inValid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [1:0] ev, rw, mr, mw, sbo, lho, ldo, hl, il;
  logic [1:0] br[2], src[2];
  logic [3:0] aop[2];
  logic [3:0] dc0;
  logic [15:0] dc1;
  int total = 0, bad = 0;
  int D[2] = '{4, 0};
  int CMAX[2] = '{15, 65535};
  logic [14:0] mwd[2];
  int mcnt[2], mrem[2];
  bit mhalt[2], mill[2];

  always #5 clk = ~clk;

  pipe_control_unit #(.ALUOP_W(4), .CNT_W(4), .DRAIN_CYCLES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .funct3(funct3), .funct7(funct7),
    .inValid(inValid), .stall(stall), .flush(flush), .exValid(ev[0]), .regWrite(rw[0]),
    .memtoReg(mr[0]), .memWrite(mw[0]), .sb(sbo[0]), .lh(lho[0]), .ld(ldo[0]),
    .branch(br[0]), .ALUsrc(src[0]), .ALUop(aop[0]), .halt(hl[0]), .illegal(il[0]), .decCount(dc0));
  pipe_control_unit #(.ALUOP_W(4), .CNT_W(16), .DRAIN_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .funct3(funct3), .funct7(funct7),
    .inValid(inValid), .stall(stall), .flush(flush), .exValid(ev[1]), .regWrite(rw[1]),
    .memtoReg(mr[1]), .memWrite(mw[1]), .sb(sbo[1]), .lh(lho[1]), .ld(ldo[1]),
    .branch(br[1]), .ALUsrc(src[1]), .ALUop(aop[1]), .halt(hl[1]), .illegal(il[1]), .decCount(dc1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // control word {exValid,regWrite,memtoReg,memWrite,sb,lh,ld,branch,ALUsrc,ALUop}
  function automatic logic [14:0] w(input bit r, m, s, b, h, l, input logic [1:0] bb, ss, input logic [3:0] a);
    return {1'b1, r, m, s, b, h, l, bb, ss, a};
  endfunction

  // returns {legal, halt, word}
  function automatic logic [16:0] ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    logic [9:0] keys[7] = '{10'h000, 10'h0A0, 10'h0A2, 10'h100, 10'h180, 10'h200, 10'h280};
    logic [3:0] ops[7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    case (op)
      7'h33: begin
        for (int i = 0; i < 7; i++) if (keys[i] == {f3, f7}) return {2'b10, w(1, 1, 0, 0, 0, 0, 0, 0, ops[i])};
        return 17'd0;
      end
      7'h13: return {2'b10, w(1, 1, 0, 0, 0, 0, 0, 1, f3 == 3'd7 ? 4'd3 : 4'd1)};
      7'h1B: return {2'b10, w(1, 1, 0, 0, 0, 0, 0, 1, 4'd0)};
      7'h67: return {2'b10, w(1, 1, 0, 0, 0, 0, 3, 1, 4'd1)};
      7'h03: return {2'b10, w(1, 0, 0, 0, f3 == 3'd2, 1, 0, 1, 4'd1)};
      7'h63: return {2'b10, w(0, 0, 0, 0, 0, 0, f3 == 3'd1 ? 2'd2 : 2'd1, 0, 4'd2)};
      7'h6F: return {2'b10, w(1, 1, 0, 0, 0, 0, 3, 2, 4'd1)};
      7'h38: return {2'b10, w(1, 1, 0, 0, 0, 0, 0, 1, 4'd7)};
      7'h23: return {2'b10, w(0, 0, 1, f3 == 3'd0, 0, 0, 0, 1, 4'd1)};
      7'h00: return {2'b11, 15'd0};
      default: return 17'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mwd[k] = '0; mcnt[k] = 0; mrem[k] = 0; mhalt[k] = 0; mill[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic [16:0] r;
    bit run, acc, lg, hh, trp;
    r = ref_dec(opCode, funct3, funct7);
    lg = r[16]; hh = r[15];
    for (int k = 0; k < 2; k++) begin
      run = !mhalt[k] && mrem[k] == 0;
      acc = run && inValid && !stall && !flush;
      if (flush) mwd[k] = '0;
      else if (!stall) mwd[k] = (run && inValid && lg && !hh) ? r[14:0] : 15'd0;
      if (acc && lg && !hh && mcnt[k] < CMAX[k]) mcnt[k]++;
      if (acc && !lg && TRAP) mill[k] = 1;
      trp = acc && (hh || (!lg && TRAP));
      if (mrem[k] > 0) begin
        mrem[k]--;
        if (mrem[k] == 0) mhalt[k] = 1;
      end else if (trp) begin
        if (D[k] == 0) mhalt[k] = 1;
        else mrem[k] = D[k];
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.ctl", k), {ev[k], rw[k], mr[k], mw[k], sbo[k], lho[k], ldo[k], br[k], src[k], aop[k]}, mwd[k]);
      chk($sformatf("u%0d.halt", k), hl[k], mhalt[k]);
      chk($sformatf("u%0d.ill", k), il[k], mill[k]);
    end
    chk("u0.cnt", dc0, mcnt[0]);
    chk("u1.cnt", dc1, mcnt[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input bit v, s, f);
    opCode = op; funct3 = f3; funct7 = f7; inValid = v; stall = s; flush = f;
  endtask

  initial begin
    logic [6:0] rops[9] = '{7'h33, 7'h13, 7'h1B, 7'h67, 7'h03, 7'h63, 7'h6F, 7'h38, 7'h23};
    logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h22};
    int r;
    @(negedge clk);
    do_reset();
    chk("rst_dc", dc0, 0);
    chk("rst_ev", ev[0], 0);
    set(7'h33, 3'd1, 7'h20, 1, 0, 0);
    tick();
    chk("add_rw", rw[0], 1);
    chk("add_mr", mr[0], 1);
    chk("add_alu", aop[0], 4'b0001);
    chk("add_ev", ev[0], 1);
    chk("add_dc", dc0, 1);
    set(7'h03, 3'd0, 7'h00, 1, 0, 0);
    tick();
    set(7'h33, 3'd1, 7'h20, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ld", ldo[0], 1);
      chk("stall_mr", mr[0], 0);
      chk("stall_dc", dc0, 2);
    end
    set(7'h63, 3'd1, 7'h00, 1, 0, 1);
    tick();
    chk("flush_ev", ev[0], 0);
    chk("flush_dc", dc0, 2);
    flush = 1'b0;
    tick();
    chk("bne_br", br[0], 2'b10);
    chk("bne_alu", aop[0], 4'b0010);
    set(7'h00, 3'd0, 7'h00, 1, 1, 0);
    tick();
    chk("hstall_u1", hl[1], 0);
    set(7'h00, 3'd0, 7'h00, 1, 0, 0);
    tick();
    chk("h0_u1", hl[1], 1);
    chk("h0_u0", hl[0], 0);
    set(7'h33, 3'd1, 7'h20, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_ev", ev[0], 0);
      chk("drain_h", hl[0], i == 3);
    end
    repeat (2) tick();
    do_reset();
    chk("rst_h", hl[0], 0);
    tick();
    chk("post_rst_ev", ev[0], 1);
    set(7'h7F, 3'd0, 7'h00, 1, 0, 0);
    tick();
    chk("ill_flag", il[0], TRAP);
    chk("ill_ev", ev[0], 0);
    set(7'h33, 3'd1, 7'h20, 1, 0, 0);
    repeat (5) tick();
    chk("ill_halt", hl[0], TRAP);
    do_reset();
    repeat (20) tick();
    chk("sat", dc0, 15);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      opCode = r < 2 ? 7'h00 : r < 5 ? 7'h7F : r < 9 ? 7'($urandom) : rops[r % 9];
      funct3 = 3'($urandom);
      funct7 = $urandom_range(0, 1) ? f7s[$urandom_range(0, 2)] : 7'($urandom);
      inValid = $urandom_range(0, 99) < 85;
      stall = $urandom_range(0, 99) < 15;
      flush = $urandom_range(0, 99) < 10;
      if ($urandom_range(0, 59) == 0) do_reset();
      else tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
